// File: rtl/test_sched_pkg.sv
// Shared constants and types for the layer-1 power-aware self-test scheduler.
// Frame layout: {cmd[3:0], payload[3:0], src[3:0], dst[3:0], 16'hBEEF}.
package test_sched_pkg;

  localparam logic [15:0] BEEF     = 16'hBEEF;
  localparam logic [3:0]  SCHED_ID = 4'd0;

  localparam logic [3:0] CMD_REQ_PWR = 4'd1;
  localparam logic [3:0] CMD_PWR_RPT = 4'd2;
  localparam logic [3:0] CMD_START   = 4'd3;
  localparam logic [3:0] CMD_DONE    = 4'd4;

  localparam int ID_W  = 4;
  localparam int PWR_W = 4;
  localparam int AP_W  = 7;

  localparam int CMD_LSB = 28;
  localparam int PAY_LSB = 24;
  localparam int SRC_LSB = 20;
  localparam int DST_LSB = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_POLL_TX, S_POLL_WAIT, S_SCHED, S_START_TX, S_RUN_WAIT, S_FINISH
  } sched_state_e;

  // ST_EMPTY marks chips never polled so they can never be picked by the fit search.
  typedef enum logic [2:0] {
    ST_EMPTY, ST_PENDING, ST_RUNNING, ST_FINISHED, ST_SKIPPED
  } chip_status_e;

  function automatic logic [31:0] make_frame(input logic [3:0] cmd, input logic [3:0] payload,
                                             input logic [3:0] src, input logic [3:0] dst);
    return {cmd, payload, src, dst, BEEF};
  endfunction

endpackage

// File: rtl/sched_chip_table.sv
// Per-chip power/status table with a lowest-ID search for a PENDING chip that
// still fits into the remaining power budget.
module sched_chip_table
  import test_sched_pkg::*;
#(
  parameter int MAX_CHIPS    = 8,
  parameter int POWER_BUDGET = 20
) (
  input  logic                 div_8_clk,
  input  logic                 rst_n,
  input  logic                 poll_we_i,
  input  logic [ID_W-1:0]      poll_id_i,
  input  logic [PWR_W-1:0]     poll_pwr_i,
  input  logic                 poll_skip_i,
  input  logic                 start_we_i,
  input  logic [ID_W-1:0]      start_id_i,
  input  logic                 done_we_i,
  input  logic [ID_W-1:0]      done_id_i,
  input  logic [AP_W-1:0]      active_power_i,
  output logic                 found_o,
  output logic [ID_W-1:0]      id_o,
  output logic [PWR_W-1:0]     start_pwr_o,
  output logic [PWR_W-1:0]     done_pwr_o,
  output logic                 done_running_o,
  output logic                 any_running_o,
  output logic [MAX_CHIPS-1:0] err_mask_o
);

  logic [PWR_W-1:0] pwr_q    [MAX_CHIPS];
  logic [PWR_W-1:0] pwr_d    [MAX_CHIPS];
  chip_status_e     status_q [MAX_CHIPS];
  chip_status_e     status_d [MAX_CHIPS];
  logic [MAX_CHIPS-1:0] fit;
  logic [MAX_CHIPS-1:0] running;

  // Entry i holds chip ID i+1.
  for (genvar gi = 0; gi < MAX_CHIPS; gi++) begin : g_chip
    assign fit[gi]        = (status_q[gi] == ST_PENDING) &&
                            ((8'(pwr_q[gi]) + 8'(active_power_i)) <= 8'(POWER_BUDGET));
    assign running[gi]    = (status_q[gi] == ST_RUNNING);
    assign err_mask_o[gi] = (status_q[gi] == ST_SKIPPED);
  end

  assign any_running_o = |running;

  always_comb begin
    pwr_d    = pwr_q;
    status_d = status_q;
    for (int i = 0; i < MAX_CHIPS; i++) begin
      if (poll_we_i && poll_id_i == ID_W'(i + 1)) begin
        pwr_d[i]    = poll_pwr_i;
        status_d[i] = poll_skip_i ? ST_SKIPPED : ST_PENDING;
      end
      if (start_we_i && start_id_i == ID_W'(i + 1)) status_d[i] = ST_RUNNING;
      if (done_we_i && done_id_i == ID_W'(i + 1)) status_d[i] = ST_FINISHED;
    end
  end

  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CHIPS; i++) begin
        pwr_q[i]    <= '0;
        status_q[i] <= ST_EMPTY;
      end
    end else begin
      pwr_q    <= pwr_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    found_o        = 1'b0;
    id_o           = '0;
    start_pwr_o    = '0;
    done_pwr_o     = '0;
    done_running_o = 1'b0;
    for (int i = MAX_CHIPS - 1; i >= 0; i--) begin
      if (fit[i]) begin
        found_o = 1'b1;
        id_o    = ID_W'(i + 1);
      end
    end
    for (int i = 0; i < MAX_CHIPS; i++) begin
      if (start_id_i == ID_W'(i + 1)) start_pwr_o = pwr_q[i];
      if (done_id_i == ID_W'(i + 1)) begin
        done_pwr_o     = pwr_q[i];
        done_running_o = running[i];
      end
    end
  end

endmodule

// File: rtl/test_scheduler.sv
// Polls discovered chips for test power, then starts self-tests concurrently
// within the power budget over the shared BEEF-framed inter-layer bus.
module test_scheduler
  import test_sched_pkg::*;
#(
  parameter int MAX_CHIPS    = 8,
  parameter int POWER_BUDGET = 20,
  parameter int TIMEOUT      = 20
) (
  input  logic                 div_8_clk,
  input  logic                 rst_n,
  input  logic                 sort_finish,
  input  logic [3:0]           chip_count,
  input  logic [31:0]          data_in,
  output logic                 tx_out,
  output logic [31:0]          data_out,
  output logic                 busy,
  output logic                 all_done,
  output logic [MAX_CHIPS-1:0] err_mask,
  output logic [AP_W-1:0]      active_power
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  idx_q, idx_d;
  logic [ID_W-1:0]  count_q, count_d;
  logic [ID_W-1:0]  sel_q, sel_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [AP_W-1:0]  active_power_q, active_power_d;

  logic             frame_ok, rpt_hit, done_acc, done_state;
  logic [3:0]       rx_cmd, rx_pay, rx_src;
  logic [ID_W-1:0]  count_clamped;
  logic             poll_we, poll_skip, start_we;
  logic             found, done_running, any_running;
  logic [ID_W-1:0]  found_id;
  logic [PWR_W-1:0] start_pwr, done_pwr;

  assign rx_cmd   = data_in[CMD_LSB +: 4];
  assign rx_pay   = data_in[PAY_LSB +: 4];
  assign rx_src   = data_in[SRC_LSB +: 4];
  assign frame_ok = (data_in[15:0] == BEEF) && (data_in[DST_LSB +: 4] == SCHED_ID);

  assign done_state = (state_q == S_SCHED) || (state_q == S_START_TX) || (state_q == S_RUN_WAIT);
  assign rpt_hit    = (state_q == S_POLL_WAIT) && frame_ok && rx_cmd == CMD_PWR_RPT && rx_src == idx_q;
  assign done_acc   = done_state && frame_ok && rx_cmd == CMD_DONE && done_running;

  assign count_clamped = (chip_count > ID_W'(MAX_CHIPS)) ? ID_W'(MAX_CHIPS) : chip_count;

  sched_chip_table #(
    .MAX_CHIPS   (MAX_CHIPS),
    .POWER_BUDGET(POWER_BUDGET)
  ) u_table (
    .div_8_clk     (div_8_clk),
    .rst_n         (rst_n),
    .poll_we_i     (poll_we),
    .poll_id_i     (idx_q),
    .poll_pwr_i    (rpt_hit ? rx_pay : '0),
    .poll_skip_i   (poll_skip),
    .start_we_i    (start_we),
    .start_id_i    (sel_q),
    .done_we_i     (done_acc),
    .done_id_i     (rx_src),
    .active_power_i(active_power_q),
    .found_o       (found),
    .id_o          (found_id),
    .start_pwr_o   (start_pwr),
    .done_pwr_o    (done_pwr),
    .done_running_o(done_running),
    .any_running_o (any_running),
    .err_mask_o    (err_mask)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    sel_d     = sel_q;
    tmo_d     = tmo_q;
    poll_we   = 1'b0;
    poll_skip = 1'b0;
    start_we  = 1'b0;
    tx_out    = 1'b0;
    data_out  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sort_finish) begin
          count_d = count_clamped;
          idx_d   = ID_W'(1);
          state_d = (count_clamped == '0) ? S_FINISH : S_POLL_TX;
        end
      end
      S_POLL_TX: begin
        tx_out   = 1'b1;
        data_out = make_frame(CMD_REQ_PWR, 4'd0, SCHED_ID, idx_q);
        tmo_d    = '0;
        state_d  = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        // A reply in the cycle the counter hits TIMEOUT still counts.
        if (rpt_hit || tmo_q == TMO_W'(TIMEOUT)) begin
          poll_we   = 1'b1;
          poll_skip = !rpt_hit || (AP_W'(rx_pay) > AP_W'(POWER_BUDGET));
          if (idx_q == count_q) begin
            state_d = S_SCHED;
          end else begin
            idx_d   = idx_q + ID_W'(1);
            state_d = S_POLL_TX;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_SCHED: begin
        if (found) begin
          sel_d   = found_id;
          state_d = S_START_TX;
        end else if (done_acc) begin
          state_d = S_SCHED;
        end else begin
          state_d = any_running ? S_RUN_WAIT : S_FINISH;
        end
      end
      S_START_TX: begin
        tx_out   = 1'b1;
        data_out = make_frame(CMD_START, 4'd0, SCHED_ID, sel_q);
        start_we = 1'b1;
        state_d  = S_SCHED;
      end
      S_RUN_WAIT: begin
        if (done_acc) state_d = S_SCHED;
      end
      S_FINISH: state_d = S_FINISH;
      default:  state_d = S_IDLE;
    endcase
  end

  assign active_power_d = active_power_q
                        + (start_we ? AP_W'(start_pwr) : AP_W'(0))
                        - (done_acc ? AP_W'(done_pwr) : AP_W'(0));

  always_ff @(posedge div_8_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      count_q        <= '0;
      sel_q          <= '0;
      tmo_q          <= '0;
      active_power_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      count_q        <= count_d;
      sel_q          <= sel_d;
      tmo_q          <= tmo_d;
      active_power_q <= active_power_d;
    end
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign all_done     = (state_q == S_FINISH);
  assign active_power = active_power_q;

endmodule

// File: tb/tb_test_scheduler.sv
// Scenario bench for test_scheduler: expected frames queued as stimulus is
// driven, observed frames captured at the falling edge and compared in order.
module tb_test_scheduler;

  logic        div_8_clk, rst_n;
  logic [31:0] data_in;
  logic        sort_finish, sort_finish_b;
  logic [3:0]  chip_count, chip_count_b;
  logic        tx_out, busy, all_done, tx_out_b, busy_b, all_done_b;
  logic [31:0] data_out, data_out_b;
  logic [7:0]  err_mask, err_mask_b;
  logic [6:0]  active_power, active_power_b;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$], obs_q[$], exp_b_q[$], obs_b_q[$];

  test_scheduler dut (
    .div_8_clk(div_8_clk), .rst_n(rst_n), .sort_finish(sort_finish), .chip_count(chip_count),
    .data_in(data_in), .tx_out(tx_out), .data_out(data_out), .busy(busy),
    .all_done(all_done), .err_mask(err_mask), .active_power(active_power)
  );

  test_scheduler #(.POWER_BUDGET(12)) dut_b (
    .div_8_clk(div_8_clk), .rst_n(rst_n), .sort_finish(sort_finish_b), .chip_count(chip_count_b),
    .data_in(data_in), .tx_out(tx_out_b), .data_out(data_out_b), .busy(busy_b),
    .all_done(all_done_b), .err_mask(err_mask_b), .active_power(active_power_b)
  );

  initial begin
    div_8_clk = 1'b0;
    forever #5 div_8_clk = ~div_8_clk;
  end

  always @(negedge div_8_clk) begin
    if (tx_out === 1'b1) obs_q.push_back(data_out);
    if (tx_out_b === 1'b1) obs_b_q.push_back(data_out_b);
  end

  function automatic logic [31:0] fr(input logic [3:0] cmd, input logic [3:0] pay,
                                     input logic [3:0] src, input logic [3:0] dst);
    return {cmd, pay, src, dst, 16'hBEEF};
  endfunction

  task automatic tick();
    @(posedge div_8_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f);
    data_in = f;
    tick();
    data_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    data_in = '0;
    sort_finish = 1'b0;
    sort_finish_b = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete(); obs_q.delete(); exp_b_q.delete(); obs_b_q.delete();
  endtask

  task automatic start_run(input bit b, input logic [3:0] cnt);
    if (b) begin chip_count_b = cnt; sort_finish_b = 1'b1; end
    else begin chip_count = cnt; sort_finish = 1'b1; end
    tick();
    sort_finish = 1'b0;
    sort_finish_b = 1'b0;
  endtask

  task automatic wait_tx(input bit b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge div_8_clk);
      if ((b ? tx_out_b : tx_out) === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) $display("FAIL wait_tx: got no strobe in 40 cycles, want a frame"); else passed++;
  endtask

  // Reply to the next REQ_PWR after `gap` idle cycles in POLL_WAIT.
  task automatic reply_poll(input bit b, input logic [3:0] id, input logic [3:0] pwr, input int gap);
    bit ok;
    wait_tx(b, ok);
    @(posedge div_8_clk);
    #1;
    repeat (gap) tick();
    send(fr(4'd2, pwr, id, 4'd0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_in = '0; sort_finish = 1'b0; sort_finish_b = 1'b0; chip_count = '0; chip_count_b = '0;
    repeat (2) tick();
    checks++; if (tx_out !== 1'b0) $display("FAIL rst_tx: got %b want 0", tx_out); else passed++;
    checks++; if (data_out !== 32'h0) $display("FAIL rst_data: got %h want 0", data_out); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (all_done !== 1'b0) $display("FAIL rst_done: got %b want 0", all_done); else passed++;
    checks++; if (err_mask !== 8'h0) $display("FAIL rst_err: got %h want 0", err_mask); else passed++;
    checks++; if (active_power !== 7'd0) $display("FAIL rst_ap: got %0d want 0", active_power); else passed++;
    rst_n = 1'b1;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, o;
    do_reset();
    start_run(1'b0, 4'd3);
    checks++; if (tx_out !== 1'b1) $display("FAIL lat_tx: got %b want 1", tx_out); else passed++;
    checks++; if (data_out !== fr(4'd1, 4'd0, 4'd0, 4'd1)) $display("FAIL lat_frame: got %h want %h", data_out, fr(4'd1, 4'd0, 4'd0, 4'd1)); else passed++;
    for (int i = 1; i <= 3; i++) exp_q.push_back(fr(4'd1, 4'd0, 4'd0, 4'(i)));
    for (int i = 1; i <= 3; i++) exp_q.push_back(fr(4'd3, 4'd0, 4'd0, 4'(i)));
    reply_poll(1'b0, 4'd1, 4'd5, 0);
    reply_poll(1'b0, 4'd2, 4'd6, 0);
    reply_poll(1'b0, 4'd3, 4'd7, 0);
    repeat (8) tick();
    checks++; if (active_power !== 7'd18) $display("FAIL b2b_ap: got %0d want 18", active_power); else passed++;
    for (int i = 1; i <= 3; i++) send(fr(4'd4, 4'd0, 4'(i), 4'd0));
    repeat (3) tick();
    checks++; if (all_done !== 1'b1) $display("FAIL b2b_done: got %b want 1", all_done); else passed++;
    checks++; if (err_mask !== 8'h0) $display("FAIL b2b_err: got %h want 0", err_mask); else passed++;
    checks++; if (active_power !== 7'd0) $display("FAIL b2b_ap0: got %0d want 0", active_power); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d frames want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL b2b_frame: got %h want %h", o, e); else passed++;
    end
    $display("back_to_back: 3 chips scheduled");
  endtask

  task automatic test_power_limit();
    logic [31:0] e, o;
    do_reset();
    start_run(1'b0, 4'd2);
    exp_q.push_back(fr(4'd1, 4'd0, 4'd0, 4'd1));
    exp_q.push_back(fr(4'd1, 4'd0, 4'd0, 4'd2));
    exp_q.push_back(fr(4'd3, 4'd0, 4'd0, 4'd1));
    reply_poll(1'b0, 4'd1, 4'd15, 0);
    reply_poll(1'b0, 4'd2, 4'd10, 20);  // lands in the cycle the counter reaches TIMEOUT
    repeat (6) tick();
    checks++; if (active_power !== 7'd15) $display("FAIL pl_ap15: got %0d want 15", active_power); else passed++;
    checks++; if (err_mask !== 8'h0) $display("FAIL pl_err: got %h want 0", err_mask); else passed++;
    exp_q.push_back(fr(4'd3, 4'd0, 4'd0, 4'd2));
    send(fr(4'd4, 4'd0, 4'd1, 4'd0));
    repeat (4) tick();
    checks++; if (active_power !== 7'd10) $display("FAIL pl_ap10: got %0d want 10", active_power); else passed++;
    send(fr(4'd4, 4'd0, 4'd2, 4'd0));
    repeat (3) tick();
    checks++; if (all_done !== 1'b1) $display("FAIL pl_done: got %b want 1", all_done); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL pl_count: got %0d frames want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL pl_frame: got %h want %h", o, e); else passed++;
    end
    $display("power_limit: 15/10 serialised");
  endtask

  task automatic test_timeout();
    logic [31:0] e, o;
    bit ok;
    do_reset();
    start_run(1'b0, 4'd2);
    exp_q.push_back(fr(4'd1, 4'd0, 4'd0, 4'd1));
    exp_q.push_back(fr(4'd1, 4'd0, 4'd0, 4'd2));
    exp_q.push_back(fr(4'd3, 4'd0, 4'd0, 4'd1));
    reply_poll(1'b0, 4'd1, 4'd4, 0);
    wait_tx(1'b0, ok);
    @(posedge div_8_clk);
    #1;
    repeat (20) tick();
    checks++; if (err_mask !== 8'h00) $display("FAIL to_early: got %h want 00", err_mask); else passed++;
    tick();
    checks++; if (err_mask !== 8'h02) $display("FAIL to_mask: got %h want 02", err_mask); else passed++;
    repeat (4) tick();
    checks++; if (active_power !== 7'd4) $display("FAIL to_ap: got %0d want 4", active_power); else passed++;
    send(fr(4'd4, 4'd0, 4'd1, 4'd0));
    repeat (3) tick();
    checks++; if (all_done !== 1'b1) $display("FAIL to_done: got %b want 1", all_done); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL to_count: got %0d frames want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL to_frame: got %h want %h", o, e); else passed++;
    end
    $display("timeout: chip 2 skipped");
  endtask

  task automatic test_over_budget();
    logic [31:0] e, o;
    do_reset();
    start_run(1'b1, 4'd2);
    exp_b_q.push_back(fr(4'd1, 4'd0, 4'd0, 4'd1));
    exp_b_q.push_back(fr(4'd1, 4'd0, 4'd0, 4'd2));
    exp_b_q.push_back(fr(4'd3, 4'd0, 4'd0, 4'd2));
    reply_poll(1'b1, 4'd1, 4'd15, 0);
    reply_poll(1'b1, 4'd2, 4'd6, 0);
    repeat (6) tick();
    checks++; if (err_mask_b !== 8'h01) $display("FAIL ob_err: got %h want 01", err_mask_b); else passed++;
    checks++; if (active_power_b !== 7'd6) $display("FAIL ob_ap: got %0d want 6", active_power_b); else passed++;
    send(fr(4'd4, 4'd0, 4'd2, 4'd0));
    repeat (3) tick();
    checks++; if (all_done_b !== 1'b1) $display("FAIL ob_done: got %b want 1", all_done_b); else passed++;
    checks++; if (obs_b_q.size() != exp_b_q.size()) $display("FAIL ob_count: got %0d frames want %0d", obs_b_q.size(), exp_b_q.size()); else passed++;
    while (exp_b_q.size() > 0 && obs_b_q.size() > 0) begin
      e = exp_b_q.pop_front(); o = obs_b_q.pop_front();
      checks++; if (o !== e) $display("FAIL ob_frame: got %h want %h", o, e); else passed++;
    end
    $display("over_budget: chip 1 skipped with budget 12");
  endtask

  task automatic test_spurious_and_reset();
    logic [31:0] e, o;
    do_reset();
    start_run(1'b0, 4'd3);
    for (int i = 1; i <= 3; i++) exp_q.push_back(fr(4'd1, 4'd0, 4'd0, 4'(i)));
    exp_q.push_back(fr(4'd3, 4'd0, 4'd0, 4'd1));
    exp_q.push_back(fr(4'd3, 4'd0, 4'd0, 4'd2));
    reply_poll(1'b0, 4'd1, 4'd4, 0);
    reply_poll(1'b0, 4'd2, 4'd5, 0);
    reply_poll(1'b0, 4'd3, 4'd12, 0);
    repeat (8) tick();
    checks++; if (active_power !== 7'd9) $display("FAIL sp_ap: got %0d want 9", active_power); else passed++;
    send(fr(4'd4, 4'd0, 4'd3, 4'd0));                 // DONE from a chip still PENDING
    send(fr(4'd4, 4'd0, 4'd1, 4'd5));                 // addressed to another ID
    send({4'd4, 4'd0, 4'd1, 4'd0, 16'hBEEE});          // broken marker
    repeat (3) tick();
    checks++; if (active_power !== 7'd9) $display("FAIL sp_ap_kept: got %0d want 9", active_power); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL sp_busy: got %b want 1", busy); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL sp_count: got %0d frames want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL sp_frame: got %h want %h", o, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (active_power !== 7'd0) $display("FAIL ar_ap: got %0d want 0", active_power); else passed++;
    checks++; if (busy !== 1'b0 || all_done !== 1'b0 || tx_out !== 1'b0) $display("FAIL ar_ctl: got busy %b done %b tx %b want 000", busy, all_done, tx_out); else passed++;
    checks++; if (err_mask !== 8'h0 || data_out !== 32'h0) $display("FAIL ar_data: got err %h data %h want 0", err_mask, data_out); else passed++;
    repeat (3) tick();
    checks++; if (obs_q.size() != 0) $display("FAIL ar_quiet: got %0d frames want 0", obs_q.size()); else passed++;
    rst_n = 1'b1;
    tick();
    start_run(1'b0, 4'd3);
    checks++; if (tx_out !== 1'b1 || data_out !== fr(4'd1, 4'd0, 4'd0, 4'd1)) $display("FAIL ar_repoll: got tx %b frame %h want 1 %h", tx_out, data_out, fr(4'd1, 4'd0, 4'd0, 4'd1)); else passed++;
    $display("spurious_and_reset: ignored frames, abort and re-poll");
  endtask

  task automatic test_zero_chips();
    do_reset();
    start_run(1'b0, 4'd0);
    checks++; if (all_done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: got done %b busy %b want 1 0", all_done, busy); else passed++;
    repeat (3) tick();
    checks++; if (obs_q.size() != 0) $display("FAIL zero_quiet: got %0d frames want 0", obs_q.size()); else passed++;
    $display("zero_chips: immediate finish");
  endtask

  task automatic test_clamp();
    logic [31:0] e, o;
    do_reset();
    start_run(1'b0, 4'd15);
    for (int i = 1; i <= 8; i++) exp_q.push_back(fr(4'd1, 4'd0, 4'd0, 4'(i)));
    for (int i = 1; i <= 8; i++) exp_q.push_back(fr(4'd3, 4'd0, 4'd0, 4'(i)));
    for (int i = 1; i <= 8; i++) reply_poll(1'b0, 4'(i), 4'd2, 0);
    repeat (20) tick();
    checks++; if (active_power !== 7'd16) $display("FAIL cl_ap: got %0d want 16", active_power); else passed++;
    for (int i = 1; i <= 8; i++) send(fr(4'd4, 4'd0, 4'(i), 4'd0));
    repeat (3) tick();
    checks++; if (all_done !== 1'b1) $display("FAIL cl_done: got %b want 1", all_done); else passed++;
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL cl_count: got %0d frames want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) $display("FAIL cl_frame: got %h want %h", o, e); else passed++;
    end
    $display("clamp: chip_count 15 served as 8");
  endtask

  initial begin
    rst_n = 1'b0;
    data_in = '0;
    sort_finish = 1'b0;
    sort_finish_b = 1'b0;
    chip_count = '0;
    chip_count_b = '0;
    test_reset();
    test_back_to_back();
    test_power_limit();
    test_timeout();
    test_over_budget();
    test_spurious_and_reset();
    test_zero_chips();
    test_clamp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
